// File: rtl/uart_axi_host.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_axi_host                                                |
// | Description : Drives a 16550-style UART via AXI4-Lite. It programs the     |
// |               divisor, line control and FIFO control registers, then polls |
// |               LSR. It moves received bytes to rx_data/rx_valid and bytes   |
// |               from tx_data/tx_valid to THR. At most one AXI transaction is |
// |               outstanding at any time.                                     |
// | Option      : UART_AXI_HOST_LINE_ERR_EN adds a sticky line_err capture of  |
// |               {framing, parity, overrun}. Without it, line_err is tied to 0.|
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+

package axi4_lite_pkg;
   typedef logic [31:0] addr_t;
   typedef logic [31:0] data_t;
   typedef logic [3:0]  strb_t;
   typedef logic [1:0]  resp_t;
   localparam resp_t RESP_OKAY = 2'b00;
endpackage

module uart_axi_host
   import axi4_lite_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter logic [15:0] DIVISOR   = 16'd27,
   parameter logic [7:0]  LCR_INIT  = 8'h03
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       init_done,
   output logic       bus_err,
   output logic [2:0] line_err,
   output addr_t      awaddr,
   output logic       awvalid,
   input  logic       awready,
   output data_t      wdata,
   output strb_t      wstrb,
   output logic       wvalid,
   input  logic       wready,
   input  logic       bvalid,
   input  resp_t      bresp,
   output logic       bready,
   output addr_t      araddr,
   output logic       arvalid,
   input  logic       arready,
   input  data_t      rdata,
   input  logic       rvalid,
   input  resp_t      rresp,
   output logic       rready
);

   typedef enum logic [3:0] {
      INIT_DLAB = 4'd0,
      INIT_DLL  = 4'd1,
      INIT_DLM  = 4'd2,
      INIT_LCR  = 4'd3,
      INIT_FCR  = 4'd4,
      POLL_LSR  = 4'd5,
      RD_RBR    = 4'd6,
      WR_THR    = 4'd7
   } state_t;

   state_t     state_q, state_d;
   logic       awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
   logic       arvalid_q, arvalid_d, rready_q, rready_d;
   addr_t      awaddr_q, awaddr_d, araddr_q, araddr_d;
   data_t      wdata_q, wdata_d;
   strb_t      wstrb_q, wstrb_d;
   logic       tx_ready_q, tx_ready_d, rx_valid_q, rx_valid_d;
   logic       init_done_q, init_done_d, bus_err_q, bus_err_d;
   logic [7:0] rx_data_q, rx_data_d, tx_byte_q, tx_byte_d;

   logic       wr_req, rd_req, wr_done, rd_done, idle;
   logic [2:0] req_reg;
   logic [7:0] req_byte;
   logic       unused_rdata;

   // Only the low byte of read data carries UART register contents.
   assign unused_rdata = ^rdata[31:8];

   assign wr_done = bready_q & bvalid;
   assign rd_done = rready_q & rvalid;
   assign idle    = ~(awvalid_q | wvalid_q | bready_q | arvalid_q | rready_q);

   // Sequencer: picks the register access for the current state, tracks AXI handshakes, branches on completion
   always_comb begin
      state_d     = state_q;
      tx_ready_d  = 1'b0;
      tx_byte_d   = tx_byte_q;
      rx_valid_d  = rx_valid_q & ~rx_ready;
      rx_data_d   = rx_data_q;
      init_done_d = init_done_q;
      bus_err_d   = bus_err_q | (wr_done & (bresp != RESP_OKAY)) | (rd_done & (rresp != RESP_OKAY));
      wr_req      = 1'b0;
      rd_req      = 1'b0;
      req_reg     = 3'd0;
      req_byte    = 8'h00;

      case (state_q)
         INIT_DLAB: begin
            wr_req = 1'b1; req_reg = 3'd3; req_byte = LCR_INIT | 8'h80;
            if (wr_done) state_d = INIT_DLL;
         end
         INIT_DLL: begin
            wr_req = 1'b1; req_reg = 3'd0; req_byte = DIVISOR[7:0];
            if (wr_done) state_d = INIT_DLM;
         end
         INIT_DLM: begin
            wr_req = 1'b1; req_reg = 3'd1; req_byte = DIVISOR[15:8];
            if (wr_done) state_d = INIT_LCR;
         end
         INIT_LCR: begin
            wr_req = 1'b1; req_reg = 3'd3; req_byte = LCR_INIT;
            if (wr_done) state_d = INIT_FCR;
         end
         INIT_FCR: begin
            wr_req = 1'b1; req_reg = 3'd2; req_byte = 8'h07;
            if (wr_done) begin
               state_d     = POLL_LSR;
               init_done_d = 1'b1;
            end
         end
         POLL_LSR: begin
            rd_req = 1'b1; req_reg = 3'd5;
            if (rd_done) begin
               if (rdata[0] && !rx_valid_q) begin
                  state_d = RD_RBR;
               end else if (tx_valid && rdata[5]) begin
                  // Byte is captured here so the strobe and the THR write refer to the same value.
                  state_d    = WR_THR;
                  tx_ready_d = 1'b1;
                  tx_byte_d  = tx_data;
               end
            end
         end
         RD_RBR: begin
            rd_req = 1'b1; req_reg = 3'd0;
            if (rd_done) begin
               rx_data_d  = rdata[7:0];
               rx_valid_d = 1'b1;
               state_d    = POLL_LSR;
            end
         end
         WR_THR: begin
            wr_req = 1'b1; req_reg = 3'd0; req_byte = tx_byte_q;
            if (wr_done) state_d = POLL_LSR;
         end
         default: state_d = INIT_DLAB;
      endcase

      // Channel bookkeeping: each valid drops after its own handshake; the response phase opens once requests are done.
      awvalid_d = awvalid_q & ~awready;
      wvalid_d  = wvalid_q & ~wready;
      bready_d  = (bready_q & ~bvalid) | ((awvalid_q | wvalid_q) & ~awvalid_d & ~wvalid_d);
      arvalid_d = arvalid_q & ~arready;
      rready_d  = (rready_q & ~rvalid) | (arvalid_q & arready);
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      araddr_d  = araddr_q;

      if (idle && wr_req) begin
         awvalid_d = 1'b1;
         wvalid_d  = 1'b1;
         awaddr_d  = BASE_ADDR + {27'd0, req_reg, 2'b00};
         wdata_d   = {24'h000000, req_byte};
         wstrb_d   = 4'b0001;
      end
      if (idle && rd_req) begin
         arvalid_d = 1'b1;
         araddr_d  = BASE_ADDR + {27'd0, req_reg, 2'b00};
      end
   end

   // State and output registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= INIT_DLAB;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         awaddr_q    <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         araddr_q    <= '0;
         tx_ready_q  <= 1'b0;
         tx_byte_q   <= 8'h00;
         rx_valid_q  <= 1'b0;
         rx_data_q   <= 8'h00;
         init_done_q <= 1'b0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         awaddr_q    <= awaddr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         araddr_q    <= araddr_d;
         tx_ready_q  <= tx_ready_d;
         tx_byte_q   <= tx_byte_d;
         rx_valid_q  <= rx_valid_d;
         rx_data_q   <= rx_data_d;
         init_done_q <= init_done_d;
         bus_err_q   <= bus_err_d;
      end
   end

`ifdef UART_AXI_HOST_LINE_ERR_EN
   logic [2:0] line_err_q, line_err_d;

   // Accumulate {framing, parity, overrun} from every LSR poll
   always_comb begin
      line_err_d = line_err_q;
      if ((state_q == POLL_LSR) && rd_done) line_err_d = line_err_q | {rdata[3], rdata[2], rdata[1]};
   end

   // Sticky line error register
   always_ff @(posedge clk) begin
      if (!rst) line_err_q <= 3'b000;
      else      line_err_q <= line_err_d;
   end

   assign line_err = line_err_q;
`else
   assign line_err = 3'b000;
`endif

   assign awvalid   = awvalid_q;
   assign wvalid    = wvalid_q;
   assign bready    = bready_q;
   assign arvalid   = arvalid_q;
   assign rready    = rready_q;
   assign awaddr    = awaddr_q;
   assign wdata     = wdata_q;
   assign wstrb     = wstrb_q;
   assign araddr    = araddr_q;
   assign tx_ready  = tx_ready_q;
   assign rx_valid  = rx_valid_q;
   assign rx_data   = rx_data_q;
   assign init_done = init_done_q;
   assign bus_err   = bus_err_q;

endmodule

`default_nettype wire

// File: doc/uart_axi_host.md
UART_AXI_HOST -- requirements
Module: uart_axi_host

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of 16550 register 0; register n sits at BASE_ADDR + 4*n.
REQ-002 SHALL have parameter DIVISOR, default 16'd27: divisor latch value programmed at init.
REQ-003 SHALL have parameter LCR_INIT, default 8'h03: line control value (8N1) programmed at init.
REQ-004 SHALL have ports, with one clock and a synchronous, active-low reset:
- clk  in  1  sole clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- tx_data  in  8  byte to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  one-cycle accept strobe for tx_data.
- rx_data  out  8  received byte.
- rx_valid  out  1  rx_data valid.
- rx_ready  in  1  consumer accepts rx_data.
- init_done  out  1  register init finished.
- bus_err  out  1  sticky non-OKAY response seen.
- line_err  out  3  sticky {framing, parity, overrun}.
- AXI4-Lite master ports (awaddr, awvalid, awready, wdata, wstrb, wvalid, wready, bvalid, bresp, bready, araddr, arvalid, arready, rdata, rvalid, rresp, rready), typed from axi4_lite_pkg.

Function
REQ-005 SHALL issue at most one AXI transaction outstanding.
REQ-006 Writes SHALL assert awvalid and wvalid in the same cycle, with wstrb=4'b0001 and data in wdata[7:0], upper bits 0.
REQ-007 awvalid and wvalid SHALL each drop the cycle after its own handshake; address, data and strobe SHALL stay stable while the valid is high.
REQ-008 bready SHALL be high from the cycle after both handshakes until bvalid is seen; the write is complete on the bvalid&bready cycle.
REQ-009 Reads SHALL hold arvalid with a stable araddr until arready; rready SHALL then be high until rvalid, and rdata[7:0] SHALL be captured on rvalid&rready.
REQ-010 FSM states: INIT_DLAB, INIT_DLL, INIT_DLM, INIT_LCR, INIT_FCR, POLL_LSR, RD_RBR, WR_THR.
REQ-011 Init sequence:
- INIT_DLAB writes LCR = LCR_INIT|8'h80.
- INIT_DLL writes DIVISOR[7:0] to register 0.
- INIT_DLM writes DIVISOR[15:8] to register 1.
- INIT_LCR writes LCR_INIT.
- INIT_FCR writes 8'h07 to register 2.
- Each state advances on write completion.
REQ-012 init_done SHALL go high the cycle after INIT_FCR completes and SHALL stay high until reset.
REQ-013 POLL_LSR SHALL read register 5 and then branch:
- If LSR[0]=1 and rx_valid=0, go to RD_RBR.
- Else if tx_valid=1 and LSR[5]=1, go to WR_THR.
- Otherwise re-poll.
- RX has priority over TX.
REQ-014 RD_RBR SHALL read register 0, load rx_data, set rx_valid the cycle after capture, then return to POLL_LSR.
REQ-015 rx_valid SHALL clear on the rx_valid&rx_ready cycle; rx_data SHALL hold while rx_valid=1.
REQ-016 WR_THR SHALL latch tx_data and pulse tx_ready for exactly one cycle on entry, write the latched byte to register 0, and return to POLL_LSR on completion.
REQ-017 tx_ready SHALL never assert before init_done; tx_valid dropping during WR_THR SHALL not abort the write.
REQ-018 A bresp or rresp other than OKAY SHALL set bus_err, and the FSM SHALL proceed as if the response were OKAY; read data from a failed read SHALL still be used.

Reset
REQ-019 While rst=0 on a clock edge: FSM=INIT_DLAB; all AXI valid/ready outputs=0; awaddr, wdata, araddr=0; wstrb=0; tx_ready, rx_valid, init_done, bus_err, line_err=0; rx_data=8'h00.
REQ-020 Reset asserted mid-transaction SHALL drop all AXI valid/ready outputs on that edge, with no completion; init SHALL restart on deassertion.

Configuration
REQ-021 With UART_AXI_HOST_LINE_ERR_EN defined, every POLL_LSR read SHALL OR {LSR[3],LSR[2],LSR[1]} into line_err, sticky until reset.
REQ-022 Without UART_AXI_HOST_LINE_ERR_EN, line_err SHALL be constant 3'b000 and no related flops SHALL exist.

Verification
REQ-023 Reset release with DIVISOR=16'h1234, LCR_INIT=8'h03 -> writes (addr,data) in order: (0x0C,0x83), (0x00,0x34), (0x04,0x12), (0x0C,0x03), (0x08,0x07); init_done rises after the fifth bresp.
REQ-024 tx_valid=1, tx_data=8'hA5, LSR read returns 8'h20 -> one tx_ready pulse, then a write of 0xA5 to 0x00; LSR=8'h00 -> no write, re-poll.
REQ-025 LSR=8'h21 with tx_valid=1 -> RBR read occurs before the THR write; RBR=8'h5A -> rx_data=8'h5A, rx_valid=1 held until rx_ready.
REQ-026 rx_valid=1, rx_ready=0, LSR=8'h01 -> no RBR read is issued.
REQ-027 Slave stalls awready 3 cycles, wready 5 cycles, bresp=2'b10 -> valids stable throughout, single write, bus_err=1.
REQ-028 With UART_AXI_HOST_LINE_ERR_EN, LSR=8'h0B -> line_err=3'b101, persists after LSR=8'h20; without the macro, line_err stays 3'b000.
